// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
//   Bundles every bus the memory arbiter touches: the I$ request/response
//   pair, the D$ request/response pair, the single main-memory port and the
//   two sticky error flags.
//   Modports:
//     slave  - the arbiter's view (takes cache requests and memory responses,
//              drives cache responses, memory requests and error flags)
//     master - the surrounding caches/memory view (exact complement)
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  icache_req_valid;
  logic [ADDR_WIDTH-1:0] icache_req_addr;
  logic                  icache_rsp_valid;
  logic [LINE_WIDTH-1:0] icache_rsp_data;
  logic                  dcache_req_valid;
  logic [ADDR_WIDTH-1:0] dcache_req_addr;
  logic                  dcache_req_is_store;
  logic [LINE_WIDTH-1:0] dcache_req_data;
  logic                  dcache_rsp_valid;
  logic [LINE_WIDTH-1:0] dcache_rsp_data;
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_is_store;
  logic [LINE_WIDTH-1:0] mem_req_data;
  logic                  mem_rsp_valid;
  logic [LINE_WIDTH-1:0] mem_rsp_data;
  logic                  err_overflow;
  logic                  err_timeout;

  modport slave (
    input  icache_req_valid, icache_req_addr,
    input  dcache_req_valid, dcache_req_addr, dcache_req_is_store, dcache_req_data,
    input  mem_rsp_valid, mem_rsp_data,
    output icache_rsp_valid, icache_rsp_data,
    output dcache_rsp_valid, dcache_rsp_data,
    output mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data,
    output err_overflow, err_timeout
  );

  modport master (
    output icache_req_valid, icache_req_addr,
    output dcache_req_valid, dcache_req_addr, dcache_req_is_store, dcache_req_data,
    output mem_rsp_valid, mem_rsp_data,
    input  icache_rsp_valid, icache_rsp_data,
    input  dcache_rsp_valid, dcache_rsp_data,
    input  mem_req_valid, mem_req_addr, mem_req_is_store, mem_req_data,
    input  err_overflow, err_timeout
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Arbitrates I$ fills and D$ fills/evicts onto one main-memory port with at
//   most one transaction outstanding, routes each memory response back to the
//   cache that issued it, and raises sticky overflow/timeout error flags.
//   Ports:
//     clock - rising-edge clock
//     reset - synchronous, active-high
//     bus   - memory_arbiter_if.slave (cache request/response buses, memory
//             request/response bus, err_overflow, err_timeout)
module memory_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_ONE  = CW'(1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  // The flag is written at the end of the WAIT_RSP cycle whose count is
  // TIMEOUT_CYCLES-2, so it becomes visible exactly TIMEOUT_CYCLES cycles
  // after the mem_req_valid cycle.
  localparam logic [CW-1:0] TMO_FIRE = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_RSP = 1'b1} state_t;
  typedef enum logic [0:0] {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

  state_t                state_r, state_nxt_s;
  port_t                 grant_r, last_grant_r, grant_sel_s;
  logic                  issue_s, rsp_hit_s;
  logic                  i_pend_r, d_pend_r;
  logic [ADDR_WIDTH-1:0] i_addr_r, d_addr_r;
  logic                  d_store_r;
  logic [LINE_WIDTH-1:0] d_data_r;
  logic                  i_busy_s, d_busy_s;
  logic                  i_accept_s, d_accept_s, i_ovf_s, d_ovf_s;
  logic [CW-1:0]         tmo_cnt_r;
  logic                  err_overflow_r, err_timeout_r;

  // A port is busy while pending or in flight; its own response ends the flight.
  always_comb begin
    rsp_hit_s  = (state_r == WAIT_RSP) && bus.mem_rsp_valid;
    i_busy_s   = i_pend_r || ((state_r == WAIT_RSP) && (grant_r == PORT_I) && !bus.mem_rsp_valid);
    d_busy_s   = d_pend_r || ((state_r == WAIT_RSP) && (grant_r == PORT_D) && !bus.mem_rsp_valid);
    i_accept_s = bus.icache_req_valid && !i_busy_s;
    d_accept_s = bus.dcache_req_valid && !d_busy_s;
    i_ovf_s    = bus.icache_req_valid && i_busy_s;
    d_ovf_s    = bus.dcache_req_valid && d_busy_s;
  end

  // Next-state and round-robin grant selection.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    grant_sel_s = PORT_I;
    case (state_r)
      IDLE: begin
        if (i_pend_r || d_pend_r) begin
          issue_s     = 1'b1;
          state_nxt_s = WAIT_RSP;
          if (i_pend_r && d_pend_r) begin
            grant_sel_s = (last_grant_r == PORT_I) ? PORT_D : PORT_I;
          end else if (d_pend_r) begin
            grant_sel_s = PORT_D;
          end else begin
            grant_sel_s = PORT_I;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_RSP: begin
        if (bus.mem_rsp_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_RSP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Memory request and cache response outputs; everything idles at zero.
  always_comb begin
    bus.mem_req_valid    = issue_s;
    bus.mem_req_addr     = {ADDR_WIDTH{1'b0}};
    bus.mem_req_is_store = 1'b0;
    bus.mem_req_data     = {LINE_WIDTH{1'b0}};
    bus.icache_rsp_valid = 1'b0;
    bus.icache_rsp_data  = {LINE_WIDTH{1'b0}};
    bus.dcache_rsp_valid = 1'b0;
    bus.dcache_rsp_data  = {LINE_WIDTH{1'b0}};
    if (issue_s && (grant_sel_s == PORT_D)) begin
      bus.mem_req_addr     = d_addr_r;
      bus.mem_req_is_store = d_store_r;
      bus.mem_req_data     = d_store_r ? d_data_r : {LINE_WIDTH{1'b0}};
    end else if (issue_s) begin
      bus.mem_req_addr = i_addr_r;
    end else begin
      bus.mem_req_addr = {ADDR_WIDTH{1'b0}};
    end
    if (rsp_hit_s && (grant_r == PORT_D)) begin
      bus.dcache_rsp_valid = 1'b1;
      bus.dcache_rsp_data  = bus.mem_rsp_data;
    end else if (rsp_hit_s) begin
      bus.icache_rsp_valid = 1'b1;
      bus.icache_rsp_data  = bus.mem_rsp_data;
    end else begin
      bus.icache_rsp_valid = 1'b0;
    end
    bus.err_overflow = err_overflow_r;
    bus.err_timeout  = err_timeout_r;
  end

  // FSM state, current grant and round-robin history.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_r      <= PORT_I;
      last_grant_r <= PORT_I;
    end else begin
      state_r <= state_nxt_s;
      if (issue_s) begin
        grant_r      <= grant_sel_s;
        last_grant_r <= grant_sel_s;
      end
    end
  end

  // Pending flags and latched request fields for both cache ports.
  always_ff @(posedge clock) begin
    if (reset) begin
      i_pend_r  <= 1'b0;
      d_pend_r  <= 1'b0;
      i_addr_r  <= {ADDR_WIDTH{1'b0}};
      d_addr_r  <= {ADDR_WIDTH{1'b0}};
      d_store_r <= 1'b0;
      d_data_r  <= {LINE_WIDTH{1'b0}};
    end else begin
      // Issue and accept never hit the same port in one cycle: a pending port is busy.
      if (issue_s && (grant_sel_s == PORT_I)) begin
        i_pend_r <= 1'b0;
      end else if (i_accept_s) begin
        i_pend_r <= 1'b1;
        i_addr_r <= bus.icache_req_addr;
      end
      if (issue_s && (grant_sel_s == PORT_D)) begin
        d_pend_r <= 1'b0;
      end else if (d_accept_s) begin
        d_pend_r  <= 1'b1;
        d_addr_r  <= bus.dcache_req_addr;
        d_store_r <= bus.dcache_req_is_store;
        d_data_r  <= bus.dcache_req_data;
      end
    end
  end

  // Saturating WAIT_RSP timeout counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else if (issue_s) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else if ((state_r == WAIT_RSP) && (tmo_cnt_r != TMO_LAST)) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_overflow_r <= 1'b0;
      err_timeout_r  <= 1'b0;
    end else begin
      if (i_ovf_s || d_ovf_s) begin
        err_overflow_r <= 1'b1;
      end
      if ((state_r == WAIT_RSP) && (tmo_cnt_r == TMO_FIRE)) begin
        err_timeout_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Directed scenarios followed by randomized cache traffic. A reference model
//   tracks pending cache requests, the outstanding memory transaction and the
//   round-robin history; expected cache responses go into a queue that an
//   independent monitor drains whenever the arbiter presents a response.
module tb_memory_arbiter;
  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int TMO = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic          st;
    logic [LW-1:0] data;
  } req_t;

  typedef struct {
    int            port;
    logic [LW-1:0] data;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  memory_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state (port 0 = I$, port 1 = D$)
  req_t          preq[2];
  bit            pend[2];
  bit            outst    = 1'b0;
  int            out_port = 0;
  int            last_g   = 0;
  int            t_start  = 0;
  bit            exp_ovf  = 1'b0;
  bit            exp_tmo  = 1'b0;
  rsp_t          exp_q[$];
  int            rsp_due  = -1;
  int            cur_lat  = 3;
  logic [LW-1:0] rsp_data_nx = '0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memory: answers cur_lat cycles after each issue, garbage data otherwise
  initial begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(posedge clock);
      #1;
      if (cyc == rsp_due) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = rsp_data_nx;
      end else begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = rnd_line();
      end
    end
  end

  // reference model: issue rules, error flags, request capture
  initial begin
    bit was_out, rsp_now, v, p0[2];
    int g;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        outst   = 1'b0;
        last_g  = 0;
        exp_ovf = 1'b0;
        exp_tmo = 1'b0;
        exp_q.delete();
      end else begin
        was_out = outst;
        rsp_now = bus.mem_rsp_valid;
        p0      = pend;
        chk("err_overflow", bus.err_overflow, exp_ovf);
        chk("err_timeout", bus.err_timeout, exp_tmo);
        if (!was_out && (pend[0] || pend[1])) begin
          if (pend[0] && pend[1]) g = 1 - last_g;
          else g = pend[1] ? 1 : 0;
          chk("mem_req_valid", bus.mem_req_valid, 1);
          chk("mem_req_addr", bus.mem_req_addr, preq[g].addr);
          chk("mem_req_is_store", bus.mem_req_is_store, (g == 1) && preq[g].st);
          chk("mem_req_data", bus.mem_req_data, ((g == 1) && preq[g].st) ? preq[g].data : '0);
          pend[g]     = 1'b0;
          last_g      = g;
          outst       = 1'b1;
          out_port    = g;
          t_start     = cyc;
          rsp_data_nx = rnd_line();
          rsp_due     = cyc + cur_lat;
          exp_q.push_back('{port: g, data: rsp_data_nx});
        end else begin
          chk("mem_req_valid", bus.mem_req_valid, 0);
        end
        if (was_out && (cyc - t_start == TMO - 1)) exp_tmo = 1'b1;
        if (was_out && rsp_now) outst = 1'b0;
        for (int p = 0; p < 2; p++) begin
          v = (p == 1) ? bus.dcache_req_valid : bus.icache_req_valid;
          if (v) begin
            if (p0[p] || (was_out && out_port == p && !rsp_now)) begin
              exp_ovf = 1'b1;
            end else begin
              pend[p] = 1'b1;
              if (p == 1) preq[p] = '{addr: bus.dcache_req_addr, st: bus.dcache_req_is_store, data: bus.dcache_req_data};
              else        preq[p] = '{addr: bus.icache_req_addr, st: 1'b0, data: '0};
            end
          end
        end
      end
    end
  end

  // monitor: pops an expected response whenever a cache response appears
  initial begin
    rsp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.icache_rsp_valid || bus.dcache_rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", {bus.icache_rsp_valid, bus.dcache_rsp_valid}, 2'b00);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_port", {bus.icache_rsp_valid, bus.dcache_rsp_valid}, (e.port == 1) ? 2'b01 : 2'b10);
            chk("rsp_data", (e.port == 1) ? bus.dcache_rsp_data : bus.icache_rsp_data, e.data);
            chk("rsp_other_data", (e.port == 1) ? bus.icache_rsp_data : bus.dcache_rsp_data, '0);
          end
        end else if (bus.mem_rsp_valid && exp_q.size() > 0) begin
          chk("rsp_missing", 0, 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  // one-cycle request pulses; fields are scrambled afterwards
  task automatic send(input bit do_i, input logic [AW-1:0] ia, input bit do_d,
                      input logic [AW-1:0] da, input bit st, input logic [LW-1:0] dd);
    bus.icache_req_valid    = do_i;
    bus.icache_req_addr     = ia;
    bus.dcache_req_valid    = do_d;
    bus.dcache_req_addr     = da;
    bus.dcache_req_is_store = st;
    bus.dcache_req_data     = dd;
    tick();
    bus.icache_req_valid    = 1'b0;
    bus.dcache_req_valid    = 1'b0;
    bus.icache_req_addr     = $urandom();
    bus.dcache_req_addr     = $urandom();
    bus.dcache_req_is_store = 1'($urandom_range(0, 1));
    bus.dcache_req_data     = rnd_line();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] a5;
    bit free_i, free_d, do_i, do_d;
    a5 = {16{8'hA5}};
    bus.icache_req_valid    = 1'b0;
    bus.icache_req_addr     = '0;
    bus.dcache_req_valid    = 1'b0;
    bus.dcache_req_addr     = '0;
    bus.dcache_req_is_store = 1'b0;
    bus.dcache_req_data     = '0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_mem_req_addr", bus.mem_req_addr, 0);
    chk("rst_mem_req_data", bus.mem_req_data, 0);
    chk("rst_mem_req_is_store", bus.mem_req_is_store, 0);
    chk("rst_irsp_valid", bus.icache_rsp_valid, 0);
    chk("rst_drsp_valid", bus.dcache_rsp_valid, 0);
    chk("rst_drsp_data", bus.dcache_rsp_data, 0);
    chk("rst_err_overflow", bus.err_overflow, 0);
    chk("rst_err_timeout", bus.err_timeout, 0);

    // D$ fill, L=5
    cur_lat = 5;
    send(1'b0, 32'h0, 1'b1, 32'h0000_1040, 1'b0, rnd_line());
    wait_n(10);

    // simultaneous pulses right after reset: D$ first
    do_reset();
    cur_lat = 4;
    send(1'b1, 32'h0000_2000, 1'b1, 32'h0000_3000, 1'b0, rnd_line());
    wait_n(15);

    // evict + I$ together, then a D$ fill while the I$ is in flight
    cur_lat = 3;
    send(1'b1, 32'h0000_4000, 1'b1, 32'h0000_5000, 1'b1, a5);
    wait_n(4);
    send(1'b0, 32'h0, 1'b1, 32'h0000_6000, 1'b0, rnd_line());
    wait_n(12);

    // second I$ pulse while the first is in flight
    cur_lat = 6;
    send(1'b1, 32'h0000_7000, 1'b0, 32'h0, 1'b0, '0);
    wait_n(2);
    send(1'b1, 32'h0000_8000, 1'b0, 32'h0, 1'b0, '0);
    wait_n(10);
    chk("ovf_flag_set", bus.err_overflow, 1);

    // memory stalls: timeout, then a late response
    cur_lat = 1000;
    send(1'b0, 32'h0, 1'b1, 32'h0000_9000, 1'b0, rnd_line());
    wait_n(9);
    chk("tmo_flag_set", bus.err_timeout, 1);
    rsp_due = cyc + 1;
    wait_n(4);
    chk("tmo_flag_sticky", bus.err_timeout, 1);

    // reset two cycles after issue, stale response three cycles later
    cur_lat = 5;
    send(1'b1, 32'h0000_A000, 1'b0, 32'h0, 1'b0, '0);
    wait_n(2);
    do_reset();
    wait_n(6);
    chk("post_rst_err_overflow", bus.err_overflow, 0);
    chk("post_rst_err_timeout", bus.err_timeout, 0);
    chk("post_rst_irsp_valid", bus.icache_rsp_valid, 0);
    cur_lat = 2;
    send(1'b0, 32'h0, 1'b1, 32'h0000_B000, 1'b0, rnd_line());
    wait_n(8);

    // randomized traffic, occasional deliberate overflow pulses
    for (int i = 0; i < 1500; i++) begin
      cur_lat = $urandom_range(1, 6);
      free_i  = !pend[0] && !(outst && out_port == 0);
      free_d  = !pend[1] && !(outst && out_port == 1);
      do_i    = ($urandom_range(0, 3) == 0) && (free_i || $urandom_range(0, 15) == 0);
      do_d    = ($urandom_range(0, 3) == 0) && (free_d || $urandom_range(0, 15) == 0);
      send(do_i, $urandom(), do_d, $urandom(), 1'($urandom_range(0, 1)), rnd_line());
    end
    wait_n(20);
    chk("drain_exp_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
